// File: rtl/box_motion_ctrl.sv
// Box origin/colour generator for the 800x600 box renderer; steps once per FRAME_DIV frame_ticks.
// Optional palette stepping on bounce is enabled by defining BOX_MOTION_COLOR_CYCLE_EN.
module box_motion_ctrl #(
    parameter int H_DISPLAY = 800,
    parameter int V_DISPLAY = 600,
    parameter int BOX_W     = 200,
    parameter int BOX_H     = 200,
    parameter int X_INIT    = 300,
    parameter int Y_INIT    = 200,
    parameter int SPEED_X   = 2,
    parameter int SPEED_Y   = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic        clk_vga,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        enable,
    output logic [10:0] box_x,
    output logic [9:0]  box_y,
    output logic [17:0] box_color,
    output logic        bounce,
    output logic        busy,
    output logic        overrun
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC_X = 2'd1;
    localparam logic [1:0] CALC_Y = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    localparam logic [11:0] X_MAX    = 12'(H_DISPLAY - BOX_W);
    localparam logic [10:0] Y_MAX    = 11'(V_DISPLAY - BOX_H);
    localparam logic [11:0] X_STEP   = 12'(SPEED_X);
    localparam logic [10:0] Y_STEP   = 11'(SPEED_Y);
    localparam logic [11:0] X_RST    = 12'(X_INIT);
    localparam logic [10:0] Y_RST    = 11'(Y_INIT);
    localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);

    logic [1:0]  state;
    logic [3:0]  div_cnt;
    logic [11:0] sx;
    logic [10:0] sy;
    logic        dir_x;  // 0 = moving +, 1 = moving -
    logic        dir_y;
    logic        hit_x;
    logic        hit_y;

    logic [11:0] x_sum, x_dif, x_next;
    logic [10:0] y_sum, y_dif, y_next;
    logic        x_hit, y_hit;

    assign busy = (state != IDLE);

    // Widened arithmetic so neither direction can wrap before the limit compare.
    always_comb begin
        x_sum = sx + X_STEP;
        x_dif = sx - X_STEP;
        if (!dir_x) begin
            x_hit  = (x_sum >= X_MAX);
            x_next = x_hit ? X_MAX : x_sum;
        end else begin
            x_hit  = (sx <= X_STEP);
            x_next = x_hit ? 12'd0 : x_dif;
        end
    end

    always_comb begin
        y_sum = sy + Y_STEP;
        y_dif = sy - Y_STEP;
        if (!dir_y) begin
            y_hit  = (y_sum >= Y_MAX);
            y_next = y_hit ? Y_MAX : y_sum;
        end else begin
            y_hit  = (sy <= Y_STEP);
            y_next = y_hit ? 11'd0 : y_dif;
        end
    end

    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= 4'd0;
            sx      <= X_RST;
            sy      <= Y_RST;
            dir_x   <= 1'b0;
            dir_y   <= 1'b0;
            hit_x   <= 1'b0;
            hit_y   <= 1'b0;
            box_x   <= X_RST[10:0];
            box_y   <= Y_RST[9:0];
            bounce  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            bounce <= 1'b0;
            if (frame_tick && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable && frame_tick) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= 4'd0;
                            state   <= CALC_X;
                        end else begin
                            div_cnt <= div_cnt + 4'd1;
                        end
                    end
                end
                CALC_X: begin
                    sx    <= x_next;
                    hit_x <= x_hit;
                    if (x_hit) begin
                        dir_x <= ~dir_x;
                    end
                    state <= CALC_Y;
                end
                CALC_Y: begin
                    sy    <= y_next;
                    hit_y <= y_hit;
                    if (y_hit) begin
                        dir_y <= ~dir_y;
                    end
                    state <= COMMIT;
                end
                default: begin
                    box_x  <= sx[10:0];
                    box_y  <= sy[9:0];
                    bounce <= hit_x | hit_y;
                    hit_x  <= 1'b0;
                    hit_y  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef BOX_MOTION_COLOR_CYCLE_EN
    logic [17:0] color_q;

    // Advances at most once per commit, so a corner hit is a single step.
    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            color_q <= 18'h3FFFF;
        end else if ((state == COMMIT) && (hit_x || hit_y)) begin
            case (color_q)
                18'h3FFFF: color_q <= 18'h3F000;
                18'h3F000: color_q <= 18'h00FC0;
                18'h00FC0: color_q <= 18'h0003F;
                default:   color_q <= 18'h3FFFF;
            endcase
        end
    end

    assign box_color = color_q;
`else
    assign box_color = 18'h3FFFF;
`endif

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Bench for box_motion_ctrl: four parameterisations share stimulus and are checked
// against an event-level reference model of the bouncing box.
module tb_box_motion_ctrl;

    localparam int NI = 4;
    localparam int XI [NI] = '{300, 599, 600, 300};
    localparam int YI [NI] = '{200, 200, 400, 200};
    localparam int FD [NI] = '{1, 1, 1, 3};
    localparam int XLIM = 600;
    localparam int YLIM = 400;
    localparam int SPX  = 2;
    localparam int SPY  = 1;

    logic        clk_vga = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] bx [NI];
    logic [9:0]  by [NI];
    logic [17:0] bc [NI];
    logic        bb [NI];
    logic        bz [NI];
    logic        bo [NI];

    int tests = 0;
    int fails = 0;

    // Reference model state: committed (m*), shadow/pending (p*), dirs 0=+ 1=-.
    int mx [NI], my [NI], px [NI], py [NI], dxm [NI], dym [NI];
    int divm [NI], pend [NI], cidx [NI];
    bit pb [NI], eb [NI], movr [NI];

    always #5 clk_vga = ~clk_vga;

    box_motion_ctrl #(.X_INIT(300), .Y_INIT(200), .FRAME_DIV(1)) dut0 (
        .clk_vga(clk_vga), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .box_x(bx[0]), .box_y(by[0]), .box_color(bc[0]), .bounce(bb[0]), .busy(bz[0]),
        .overrun(bo[0]));
    box_motion_ctrl #(.X_INIT(599), .Y_INIT(200), .FRAME_DIV(1)) dut1 (
        .clk_vga(clk_vga), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .box_x(bx[1]), .box_y(by[1]), .box_color(bc[1]), .bounce(bb[1]), .busy(bz[1]),
        .overrun(bo[1]));
    box_motion_ctrl #(.X_INIT(600), .Y_INIT(400), .FRAME_DIV(1)) dut2 (
        .clk_vga(clk_vga), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .box_x(bx[2]), .box_y(by[2]), .box_color(bc[2]), .bounce(bb[2]), .busy(bz[2]),
        .overrun(bo[2]));
    box_motion_ctrl #(.X_INIT(300), .Y_INIT(200), .FRAME_DIV(3)) dut3 (
        .clk_vga(clk_vga), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .box_x(bx[3]), .box_y(by[3]), .box_color(bc[3]), .bounce(bb[3]), .busy(bz[3]),
        .overrun(bo[3]));

    function automatic logic [17:0] exp_col(input int idx);
        logic [17:0] tbl [4];
        tbl = '{18'h3FFFF, 18'h3F000, 18'h00FC0, 18'h0003F};
`ifdef BOX_MOTION_COLOR_CYCLE_EN
        return tbl[idx];
`else
        return tbl[0];
`endif
    endfunction

    // One bounded step: move by spd, clamp to [0, lim] and reverse on contact.
    task automatic move(inout int p, inout int d, input int lim, input int spd, output bit hit);
        hit = 1'b0;
        if (d == 0) begin
            if (p + spd >= lim) begin p = lim; d = 1; hit = 1'b1; end
            else p = p + spd;
        end else begin
            if (p <= spd) begin p = 0; d = 0; hit = 1'b1; end
            else p = p - spd;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mx[i] = XI[i]; my[i] = YI[i]; px[i] = XI[i]; py[i] = YI[i];
            dxm[i] = 0; dym[i] = 0; divm[i] = 0; pend[i] = 0; cidx[i] = 0;
            pb[i] = 1'b0; eb[i] = 1'b0; movr[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit ft, input bit en);
        bit hx, hy;
        for (int i = 0; i < NI; i++) begin
            eb[i] = 1'b0;
            if (pend[i] > 0) begin
                if (ft) movr[i] = 1'b1;
                pend[i]--;
                if (pend[i] == 0) begin
                    mx[i] = px[i];
                    my[i] = py[i];
                    if (pb[i]) begin
                        eb[i] = 1'b1;
                        cidx[i] = (cidx[i] + 1) % 4;
                    end
                end
            end else if (en && ft) begin
                divm[i]++;
                if (divm[i] == FD[i]) begin
                    divm[i] = 0;
                    pend[i] = 3;
                    move(px[i], dxm[i], XLIM, SPX, hx);
                    move(py[i], dym[i], YLIM, SPY, hy);
                    pb[i] = hx | hy;
                end
            end
        end
    endtask

    // Drive inputs for one clock, advance the model, return 1 time unit after the edge.
    task automatic cycle(input bit ft, input bit en);
        frame_tick = ft;
        enable = en;
        @(posedge clk_vga);
        model_edge(ft, en);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        frame_tick = 1'b0;
        enable = 1'b1;
        model_reset();
        @(posedge clk_vga);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (bx[i] !== 11'(XI[i]) || by[i] !== 10'(YI[i]) || bc[i] !== 18'h3FFFF ||
                bz[i] !== 1'b0 || bo[i] !== 1'b0 || bb[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset[%0d] got x=%0d y=%0d c=%h busy=%b ovr=%b bnc=%b want x=%0d y=%0d c=3ffff 0 0 0",
                         i, bx[i], by[i], bc[i], bz[i], bo[i], bb[i], XI[i], YI[i]);
            end
        end
    endtask

    task automatic test_single_step();
        apply_reset();
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (bz[0] !== 1'b1 || bx[0] !== 11'd300 || by[0] !== 10'd200 || bb[0] !== 1'b0) begin
                fails++;
                $display("FAIL step_wait[%0d] got busy=%b x=%0d y=%0d bnc=%b want 1 300 200 0",
                         k, bz[0], bx[0], by[0], bb[0]);
            end
            if (k < 2) cycle(1'b0, 1'b1);
        end
        cycle(1'b0, 1'b1);
        tests++;
        if (bz[0] !== 1'b0 || bx[0] !== 11'd302 || by[0] !== 10'd201 || bb[0] !== 1'b0) begin
            fails++;
            $display("FAIL step_commit got busy=%b x=%0d y=%0d bnc=%b want 0 302 201 0",
                     bz[0], bx[0], by[0], bb[0]);
        end
    endtask

    task automatic test_edges();
        logic [17:0] c1;
        apply_reset();
`ifdef BOX_MOTION_COLOR_CYCLE_EN
        c1 = 18'h3F000;
`else
        c1 = 18'h3FFFF;
`endif
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
        tests++;
        if (bx[1] !== 11'd600 || bb[1] !== 1'b1 || bc[1] !== c1) begin
            fails++;
            $display("FAIL edge_x_hit got x=%0d bnc=%b c=%h want 600 1 %h", bx[1], bb[1], bc[1], c1);
        end
        tests++;
        if (bx[2] !== 11'd600 || by[2] !== 10'd400 || bb[2] !== 1'b1 || bc[2] !== c1) begin
            fails++;
            $display("FAIL corner_hit got x=%0d y=%0d bnc=%b c=%h want 600 400 1 %h",
                     bx[2], by[2], bb[2], bc[2], c1);
        end
        cycle(1'b0, 1'b1);
        tests++;
        if (bb[1] !== 1'b0 || bb[2] !== 1'b0 || bc[2] !== c1) begin
            fails++;
            $display("FAIL bounce_pulse got bnc1=%b bnc2=%b c2=%h want 0 0 %h", bb[1], bb[2], bc[2], c1);
        end
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
        tests++;
        if (bx[1] !== 11'd598 || bb[1] !== 1'b0 || bc[1] !== c1) begin
            fails++;
            $display("FAIL edge_x_back got x=%0d bnc=%b c=%h want 598 0 %h", bx[1], bb[1], bc[1], c1);
        end
        tests++;
        if (bx[2] !== 11'd598 || by[2] !== 10'd399 || bb[2] !== 1'b0 || bc[2] !== c1) begin
            fails++;
            $display("FAIL corner_back got x=%0d y=%0d bnc=%b c=%h want 598 399 0 %h",
                     bx[2], by[2], bb[2], bc[2], c1);
        end
    endtask

    task automatic test_frame_div();
        int ex [5] = '{300, 300, 302, 302, 302};
        apply_reset();
        for (int t = 0; t < 3; t++) begin
            cycle(1'b1, 1'b1);
            for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1);
            tests++;
            if (bx[3] !== 11'(ex[t]) || by[3] !== 10'(ex[t] == 300 ? 200 : 201)) begin
                fails++;
                $display("FAIL div_tick[%0d] got x=%0d y=%0d want x=%0d", t, bx[3], by[3], ex[t]);
            end
        end
        for (int t = 0; t < 5; t++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0);
        tests++;
        if (bx[3] !== 11'd302 || by[3] !== 10'd201 || bz[3] !== 1'b0) begin
            fails++;
            $display("FAIL div_disabled got x=%0d y=%0d busy=%b want 302 201 0", bx[3], by[3], bz[3]);
        end
        // Divider must still be at zero: two more ticks do nothing, the third steps.
        for (int t = 0; t < 3; t++) begin
            cycle(1'b1, 1'b1);
            for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1);
            tests++;
            if (bx[3] !== 11'(t < 2 ? 302 : 304)) begin
                fails++;
                $display("FAIL div_held[%0d] got x=%0d want %0d", t, bx[3], t < 2 ? 302 : 304);
            end
        end
    endtask

    task automatic test_overrun_and_abort();
        apply_reset();
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        tests++;
        if (bx[0] !== 11'd302 || by[0] !== 10'd201 || bo[0] !== 1'b1) begin
            fails++;
            $display("FAIL overrun got x=%0d y=%0d ovr=%b want 302 201 1", bx[0], by[0], bo[0]);
        end
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1);
        tests++;
        if (bx[0] !== 11'd302 || by[0] !== 10'd201 || bo[0] !== 1'b1) begin
            fails++;
            $display("FAIL overrun_one_step got x=%0d y=%0d ovr=%b want 302 201 1", bx[0], by[0], bo[0]);
        end
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        tests++;
        if (bx[0] !== 11'd300 || by[0] !== 10'd200 || bo[0] !== 1'b0 || bz[0] !== 1'b0) begin
            fails++;
            $display("FAIL abort_async got x=%0d y=%0d ovr=%b busy=%b want 300 200 0 0",
                     bx[0], by[0], bo[0], bz[0]);
        end
        model_reset();
        @(posedge clk_vga);
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1);
        tests++;
        if (bx[0] !== 11'd300 || by[0] !== 10'd200 || bb[0] !== 1'b0 || bz[0] !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_commit got x=%0d y=%0d bnc=%b busy=%b want 300 200 0 0",
                     bx[0], by[0], bb[0], bz[0]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
            for (int i = 0; i < NI; i++) begin
                tests++;
                if (bx[i] !== 11'(mx[i]) || by[i] !== 10'(my[i]) || bb[i] !== eb[i] ||
                    bz[i] !== (pend[i] > 0) || bo[i] !== movr[i] || bc[i] !== exp_col(cidx[i])) begin
                    fails++;
                    $display("FAIL rand[%0d] cyc %0d got x=%0d y=%0d b=%b busy=%b o=%b c=%h want x=%0d y=%0d b=%b busy=%b o=%b c=%h",
                             i, n, bx[i], by[i], bb[i], bz[i], bo[i], bc[i],
                             mx[i], my[i], eb[i], pend[i] > 0, movr[i], exp_col(cidx[i]));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk_vga);
        #1;
        test_reset();
        test_single_step();
        test_edges();
        test_frame_div();
        test_overrun_and_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
